coincidence_trigger: RTL and testbench

- Parametrised N-channel coincidence trigger for the MUSE cosmic/scintillator trigger path.
- Replaces the fixed 6-input combinational AND with a registered unit. It adds:
  - per-channel rising-edge detect and a programmable coincidence window (pulse stretch);
  - channel masking and AND / majority modes;
  - a fixed-width output pulse with programmable deadtime;
  - a saturating trigger counter.
- Sits between the discriminated detector inputs (already synchronous to clk) and the trigger output logic.

---
 rtl/coincidence_trigger.sv | 167 ++++++++++++++++
 tb/tb_coincidence_trigger.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coincidence_trigger.sv
// Registered N-channel coincidence trigger: edge detect, window stretch, AND/majority modes,
// fixed-width output pulse, deadtime and a saturating trigger count. Optional veto input: COINC_VETO_EN.
module coincidence_trigger #(
    parameter int N_CH   = 6,
    parameter int WIN_W  = 4,
    parameter int OUT_W  = 4,
    parameter int DEAD_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           in,
    input  logic [N_CH-1:0]           ch_mask,
    input  logic                      mode,
    input  logic [$clog2(N_CH+1)-1:0] threshold,
    input  logic [WIN_W-1:0]          win_len,
    input  logic [OUT_W-1:0]          out_len,
    input  logic [DEAD_W-1:0]         dead_len,
`ifdef COINC_VETO_EN
    input  logic                      veto,
`endif
    output logic                      trig_out,
    output logic                      busy,
    output logic [CNT_W-1:0]          trig_count
);

    localparam int TH_W = $clog2(N_CH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [N_CH-1:0]   in_q;
    logic [N_CH-1:0]   in_qq;
    logic [N_CH-1:0]   edge_det;
    logic [N_CH-1:0]   stretch;
    logic [N_CH-1:0]   act;
    logic [WIN_W-1:0]  cnt [N_CH];
    logic [OUT_W-1:0]  out_cnt;
    logic [OUT_W-1:0]  out_cnt_nxt;
    logic [DEAD_W-1:0] dead_cnt;
    logic [DEAD_W-1:0] dead_cnt_nxt;
    logic [TH_W-1:0]   pop;
    logic [TH_W-1:0]   thr_eff;
    logic              and_ok;
    logic              cond;
    logic              fire;
    logic              hold_win;
    logic              veto_act;

`ifdef COINC_VETO_EN
    assign veto_act = veto;
`else
    assign veto_act = 1'b0;
`endif

    // Both stages load the live input during reset so a level held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q  <= in;
            in_qq <= in;
        end else begin
            in_q  <= in;
            in_qq <= in_q;
        end
    end

    assign edge_det = in_q & ~in_qq;

    // Windows are discarded on the firing edge and while busy, so one window never triggers twice.
    assign hold_win = (state != IDLE) || fire || veto_act;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst || hold_win) begin
                cnt[i] <= '0;
            end else if (edge_det[i]) begin
                cnt[i] <= win_len;
            end else if (cnt[i] != '0) begin
                cnt[i] <= cnt[i] - WIN_W'(1);
            end
        end
    end

    always_comb begin
        stretch = '0;
        for (int i = 0; i < N_CH; i++) begin
            stretch[i] = edge_det[i] | (cnt[i] != '0);
        end
    end

    assign act = stretch & ch_mask;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            pop = pop + TH_W'(act[i]);
        end
    end

    assign thr_eff = (threshold == '0) ? TH_W'(1) : threshold;
    assign and_ok  = (&(stretch | ~ch_mask)) && (|ch_mask);
    assign cond    = mode ? (pop >= thr_eff) : and_ok;
    assign fire    = (state == IDLE) && cond && !veto_act;

    always_comb begin
        state_nxt    = state;
        out_cnt_nxt  = out_cnt;
        dead_cnt_nxt = dead_cnt;
        case (state)
            IDLE: begin
                if (fire) begin
                    state_nxt   = FIRE;
                    out_cnt_nxt = out_len;
                end
            end
            FIRE: begin
                if (out_cnt == '0) begin
                    if (dead_len != '0) begin
                        state_nxt    = DEAD;
                        dead_cnt_nxt = dead_len;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    out_cnt_nxt = out_cnt - OUT_W'(1);
                end
            end
            DEAD: begin
                if (dead_cnt <= DEAD_W'(1)) begin
                    state_nxt    = IDLE;
                    dead_cnt_nxt = '0;
                end else begin
                    dead_cnt_nxt = dead_cnt - DEAD_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_cnt    <= '0;
            dead_cnt   <= '0;
            trig_out   <= 1'b0;
            busy       <= 1'b0;
            trig_count <= '0;
        end else begin
            state    <= state_nxt;
            out_cnt  <= out_cnt_nxt;
            dead_cnt <= dead_cnt_nxt;
            trig_out <= (state_nxt == FIRE);
            busy     <= (state_nxt != IDLE);
            if (fire && (trig_count != '1)) begin
                trig_count <= trig_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_coincidence_trigger.sv
// Bench for coincidence_trigger: event-time model of windows, pulse and deadtime checked every cycle,
// plus directed scenarios with literal expectations. Veto scenarios compile with COINC_VETO_EN.
module tb_coincidence_trigger;

    localparam int N = 6;

    logic         clk;
    logic         rst;
    logic [N-1:0] in;
    logic [N-1:0] ch_mask;
    logic         mode;
    logic [2:0]   threshold;
    logic [3:0]   win_len;
    logic [3:0]   out_len;
    logic [7:0]   dead_len;
`ifdef COINC_VETO_EN
    logic         veto;
`endif
    logic         trig_out;
    logic         busy;
    logic [15:0]  trig_count;
    logic         sat_trig;
    logic         sat_busy;
    logic [1:0]   sat_count;

    int n_checks = 0;
    int n_fail   = 0;

    coincidence_trigger #(.N_CH(N), .WIN_W(4), .OUT_W(4), .DEAD_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in(in), .ch_mask(ch_mask), .mode(mode), .threshold(threshold),
        .win_len(win_len), .out_len(out_len), .dead_len(dead_len),
`ifdef COINC_VETO_EN
        .veto(veto),
`endif
        .trig_out(trig_out), .busy(busy), .trig_count(trig_count)
    );

    coincidence_trigger #(.N_CH(N), .WIN_W(4), .OUT_W(4), .DEAD_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in(in), .ch_mask(ch_mask), .mode(mode), .threshold(threshold),
        .win_len(win_len), .out_len(out_len), .dead_len(dead_len),
`ifdef COINC_VETO_EN
        .veto(veto),
`endif
        .trig_out(sat_trig), .busy(sat_busy), .trig_count(sat_count)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- model (event times, edge index = cyc) ----------------
    int  cyc = 0;
    int  busy_end = -1;
    int  pulse_end = -1;
    int  m_count = 0;
    int  win_end[N];
    bit  win_valid[N];
    logic [N-1:0] prev_in;
    bit  exp_trig = 1'b0;
    bit  exp_busy = 1'b0;

    always @(posedge clk) begin
        int  hits;
        bit  all_ok;
        bit  cond;
        bit  veto_now;
        int  thr;
        cyc++;
`ifdef COINC_VETO_EN
        veto_now = veto;
`else
        veto_now = 1'b0;
`endif
        if (rst) begin
            prev_in   = in;
            m_count   = 0;
            busy_end  = -1;
            pulse_end = -1;
            for (int i = 0; i < N; i++) win_valid[i] = 1'b0;
        end else begin
            hits   = 0;
            all_ok = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (ch_mask[i]) begin
                    if (win_valid[i] && cyc <= win_end[i]) hits++;
                    else all_ok = 1'b0;
                end
            end
            thr  = (threshold == 0) ? 1 : int'(threshold);
            cond = (ch_mask != 0) && (mode ? (hits >= thr) : all_ok);
            if ((cyc - 1 > busy_end) && cond && !veto_now) begin
                pulse_end = cyc + int'(out_len);
                busy_end  = cyc + int'(out_len) + int'(dead_len);
                if (m_count < 65535) m_count++;
                for (int i = 0; i < N; i++) win_valid[i] = 1'b0;
            end
            if (veto_now) begin
                for (int i = 0; i < N; i++) win_valid[i] = 1'b0;
            end
            // A rise opens a window of win_len+1 decision edges unless the trigger is busy.
            for (int i = 0; i < N; i++) begin
                if (in[i] && !prev_in[i] && cyc > busy_end) begin
                    win_valid[i] = 1'b1;
                    win_end[i]   = cyc + 1 + int'(win_len);
                end
            end
            prev_in = in;
        end
        exp_trig = !rst && (cyc <= pulse_end);
        exp_busy = !rst && (cyc <= busy_end);
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("trig_out", 32'(trig_out), 32'(exp_trig));
            check("busy", 32'(busy), 32'(exp_busy));
            check("trig_count", 32'(trig_count), 32'(m_count));
            check("sat_trig", 32'(sat_trig), 32'(exp_trig));
            check("sat_busy", 32'(sat_busy), 32'(exp_busy));
            check("sat_count", 32'(sat_count), (m_count > 3) ? 32'd3 : 32'(m_count));
        end
    end

    // ---------------- pulse monitor ----------------
    int   pulse_cnt = 0;
    int   high_cycles = 0;
    int   first_trig_cyc = 0;
    logic trig_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        if (trig_out === 1'b1) begin
            high_cycles++;
            if (trig_prev !== 1'b1) begin
                pulse_cnt++;
                first_trig_cyc = cyc;
            end
        end
        trig_prev = trig_out;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] bits);
        in = in | bits;
        tick(1);
        in = in & ~bits;
    endtask

    task automatic clear_mon();
        pulse_cnt   = 0;
        high_cycles = 0;
    endtask

    // ---------------- stimulus ----------------
    int last_cyc;

    initial begin
        rst       = 1'b1;
        in        = '0;
        ch_mask   = 6'h3F;
        mode      = 1'b0;
        threshold = 3'd3;
        win_len   = 4'd3;
        out_len   = 4'd1;
        dead_len  = 8'd0;
`ifdef COINC_VETO_EN
        veto      = 1'b0;
`endif
        tick(3);
        check("reset_trig_out", 32'(trig_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", 32'(trig_count), 32'd0);
        rst = 1'b0;
        tick(2);

        // AND mode, all six channels rise over three consecutive cycles
        clear_mon();
        in[1:0] = 2'b11;
        tick(1);
        in[3:2] = 2'b11;
        tick(1);
        in[5:4] = 2'b11;
        last_cyc = cyc;
        tick(8);
        check("and_all_pulses", 32'(pulse_cnt), 32'd1);
        check("and_all_width", 32'(high_cycles), 32'd2);
        check("and_all_latency", 32'(first_trig_cyc - last_cyc), 32'd2);
        check("and_all_count", 32'(trig_count), 32'd1);
        in = '0;
        tick(5);

        // ch5 rises outside the window of ch0..ch4
        do_reset();
        clear_mon();
        in[4:0] = 5'h1F;
        tick(5);
        in[5] = 1'b1;
        tick(8);
        check("late_ch5_pulses", 32'(pulse_cnt), 32'd0);
        check("late_ch5_count", 32'(trig_count), 32'd0);
        in = '0;
        tick(5);

        // majority mode
        mode = 1'b1;
        threshold = 3'd3;
        clear_mon();
        pulse(6'b010101);
        tick(8);
        check("maj3_hit", 32'(pulse_cnt), 32'd1);
        pulse(6'b000101);
        tick(8);
        check("maj3_two_only", 32'(pulse_cnt), 32'd1);
        threshold = 3'd0;
        pulse(6'b000010);
        tick(8);
        check("maj_thr0_single", 32'(pulse_cnt), 32'd2);
        check("maj_count", 32'(trig_count), 32'd2);

        // AND mode with partial and empty mask
        mode = 1'b0;
        ch_mask = 6'h03;
        clear_mon();
        pulse(6'b000011);
        tick(8);
        check("mask03_hit", 32'(pulse_cnt), 32'd1);
        ch_mask = 6'h00;
        pulse(6'h3F);
        tick(8);
        check("mask0_none", 32'(pulse_cnt), 32'd1);
        mode = 1'b1;
        pulse(6'h3F);
        tick(8);
        check("mask0_maj_none", 32'(pulse_cnt), 32'd1);
        mode = 1'b0;
        ch_mask = 6'h03;

        // level held high through reset release
        in = 6'h3F;
        do_reset();
        clear_mon();
        tick(10);
        check("held_high_none", 32'(pulse_cnt), 32'd0);
        check("held_high_count", 32'(trig_count), 32'd0);
        in = '0;
        tick(3);

        // deadtime: out_len=0, dead_len=10
        out_len = 4'd0;
        dead_len = 8'd10;
        clear_mon();
        pulse(6'b000011);
        tick(2);
        check("dead_first_width", 32'(high_cycles), 32'd1);
        tick(4);
        pulse(6'b000011);
        check("dead_busy_mid", 32'(busy), 32'd1);
        tick(6);
        pulse(6'b000011);
        tick(8);
        check("dead_pulses", 32'(pulse_cnt), 32'd2);
        check("dead_count", 32'(trig_count), 32'd2);
        tick(6);

        // saturation of the 2-bit counter after five triggers
        dead_len = 8'd0;
        repeat (3) begin
            pulse(6'b000011);
            tick(6);
        end
        check("sat_main_count", 32'(trig_count), 32'd5);
        check("sat_small_count", 32'(sat_count), 32'd3);

        // reset in the middle of a pulse
        out_len = 4'd8;
        pulse(6'b000011);
        tick(3);
        check("midfire_trig_high", 32'(trig_out), 32'd1);
        rst = 1'b1;
        tick(1);
        check("midfire_rst_trig", 32'(trig_out), 32'd0);
        check("midfire_rst_count", 32'(trig_count), 32'd0);
        rst = 1'b0;
        tick(5);

`ifdef COINC_VETO_EN
        out_len = 4'd3;
        clear_mon();
        veto = 1'b1;
        pulse(6'b000011);
        tick(6);
        veto = 1'b0;
        tick(4);
        check("veto_block", 32'(pulse_cnt), 32'd0);
        pulse(6'b000011);
        tick(2);
        veto = 1'b1;
        tick(8);
        veto = 1'b0;
        check("veto_midfire_pulses", 32'(pulse_cnt), 32'd1);
        check("veto_midfire_width", 32'(high_cycles), 32'd4);
        tick(4);
`endif

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
